// File: rtl/poly_mem_pkg.sv
// poly_mem_pkg: shared widths, coefficient count and clear-FSM states for the coefficient RAM
package poly_mem_pkg;
  localparam int DATA_W = 26;
  localparam int ADDR_W = 11;
  localparam int P_COEF = 761;
  localparam int RAM_AW = $clog2(P_COEF);
  typedef enum logic [1:0] {IDLE, CLEARING, DONE} clr_state_t;
endpackage

// File: rtl/poly_coef_ram.sv
// poly_coef_ram: simple dual-port RAM, one write port and one registered read port
module poly_coef_ram #(
  parameter int DW = 26,
  parameter int DEPTH = 761,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/poly_mem_arbiter.sv
// poly_mem_arbiter: clear-priority write arbiter, bounded read port and clear-pass tracker.
// Define READ_BYPASS_EN for write-first forwarding on same-address read/write.
module poly_mem_arbiter
  import poly_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_we,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [DATA_W-1:0] clr_data,
  input  logic              cmp_we,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [DATA_W-1:0] cmp_data,
  output logic              cmp_stall,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              oob_err
);
  localparam logic [ADDR_W-1:0] P_END = ADDR_W'(P_COEF);
  logic w_we, ram_we, rd_ok, clr_ok, rd_zero;
  logic [ADDR_W-1:0] w_addr, nxt, cnt, cnt_n;
  logic [DATA_W-1:0] w_data, ram_q;
  clr_state_t state, state_n;
  assign cmp_stall = cmp_we & clr_we;
  assign w_we = clr_we | cmp_we;
  assign w_addr = clr_we ? clr_addr : cmp_addr;
  assign w_data = clr_we ? clr_data : cmp_data;
  assign ram_we = w_we & (w_addr < P_END);
  assign rd_ok = rd_en & (rd_addr < P_END);
  assign clr_ok = clr_we & (clr_addr < P_END);
  assign clr_busy = state == CLEARING;
  assign clr_done = state == DONE;
  // any legal clear write outside CLEARING opens a fresh pass with count 1
  always_comb begin
    nxt = (state == CLEARING) ? cnt + 1'b1 : ADDR_W'(1);
    state_n = clr_ok ? ((nxt == P_END) ? DONE : CLEARING) : state;
    cnt_n = clr_ok ? nxt : cnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rd_valid <= 1'b0;
      rd_zero <= 1'b1;
      oob_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rd_valid <= rd_en;
      oob_err <= w_we & ~ram_we;
      if (rd_en) rd_zero <= ~rd_ok;
    end
  end
`ifdef READ_BYPASS_EN
  logic byp;
  logic [DATA_W-1:0] byp_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp <= 1'b0;
      byp_data <= '0;
    end else if (rd_en) begin
      byp <= ram_we && (w_addr == rd_addr);
      byp_data <= w_data;
    end
  end
  assign rd_data = rd_zero ? '0 : byp ? byp_data : ram_q;
`else
  assign rd_data = rd_zero ? '0 : ram_q;
`endif
  poly_coef_ram #(.DW(DATA_W), .DEPTH(P_COEF), .AW(RAM_AW)) u_ram (
    .clk(clk),
    .we(ram_we),
    .waddr(w_addr[RAM_AW-1:0]),
    .wdata(w_data),
    .re(rd_ok),
    .raddr(rd_addr[RAM_AW-1:0]),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_poly_mem_arbiter.sv
// tb_poly_mem_arbiter: directed and randomized checks against an array-based reference model
module tb_poly_mem_arbiter;
  localparam int P = 761;
  logic clk = 1'b0, rst_n = 1'b0;
  logic clr_we = 1'b0, cmp_we = 1'b0, rd_en = 1'b0;
  logic [10:0] clr_addr = '0, cmp_addr = '0, rd_addr = '0;
  logic [25:0] clr_data = '0, cmp_data = '0;
  logic cmp_stall, rd_valid, clr_busy, clr_done, oob_err;
  logic [25:0] rd_data;
  logic [25:0] mem [0:P-1];
  logic [25:0] exp_rd = '0;
  bit exp_valid, exp_oob;
  int cnt = 0, phase = 0;
  int total = 0, bad = 0;

  poly_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .clr_we(clr_we), .clr_addr(clr_addr), .clr_data(clr_data),
    .cmp_we(cmp_we), .cmp_addr(cmp_addr), .cmp_data(cmp_data),
    .cmp_stall(cmp_stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_busy(clr_busy), .clr_done(clr_done), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit cw, input int ca, input logic [25:0] cd,
                       input bit mw, input int ma, input logic [25:0] md,
                       input bit re, input int ra);
    clr_we = cw; clr_addr = 11'(ca); clr_data = cd;
    cmp_we = mw; cmp_addr = 11'(ma); cmp_data = md;
    rd_en = re; rd_addr = 11'(ra);
  endtask

  // model: phase 0 idle, 1 clearing, 2 done; cnt counts legal clear writes in the pass
  task automatic tick();
    bit we;
    int wa;
    logic [25:0] wd;
    @(posedge clk);
    if (!rst_n) begin
      phase = 0; cnt = 0; exp_rd = '0; exp_valid = 0; exp_oob = 0;
    end else begin
      exp_valid = rd_en;
      if (rd_en) exp_rd = (int'(rd_addr) >= P) ? 26'd0 : mem[rd_addr];
      we = clr_we || cmp_we;
      wa = clr_we ? int'(clr_addr) : int'(cmp_addr);
      wd = clr_we ? clr_data : cmp_data;
      exp_oob = we && wa >= P;
      if (we && wa < P) begin
`ifdef READ_BYPASS_EN
        if (rd_en && int'(rd_addr) == wa) exp_rd = wd;
`endif
        mem[wa] = wd;
      end
      if (clr_we && int'(clr_addr) < P) begin
        cnt = (phase == 1) ? cnt + 1 : 1;
        phase = (cnt == P) ? 2 : 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rd_data !== 26'd0) begin bad++; $display("FAIL reset rd_data got %0h exp 0", rd_data); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset rd_valid got %b exp 0", rd_valid); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset clr_busy got %b exp 0", clr_busy); end
    total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL reset clr_done got %b exp 0", clr_done); end
    total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL reset oob_err got %b exp 0", oob_err); end
  endtask

  task automatic test_full_clear();
    for (int a = 0; a < P; a++) begin
      drive(1, a, 0, 0, 0, 0, 0, 0);
      tick();
      total++; if (clr_busy !== (a < P - 1)) begin bad++; $display("FAIL clear busy a=%0d got %b exp %b", a, clr_busy, a < P - 1); end
      total++; if (clr_done !== (a == P - 1)) begin bad++; $display("FAIL clear done a=%0d got %b exp %b", a, clr_done, a == P - 1); end
    end
    foreach (mem[i]) mem[i] = 26'd0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, k * 380);
      tick();
      total++; if (rd_data !== 26'd0 || rd_valid !== 1'b1) begin bad++; $display("FAIL clear read addr=%0d got %0h/%b exp 0/1", k * 380, rd_data, rd_valid); end
    end
  endtask

  task automatic test_priority();
    drive(1, 5, 0, 1, 5, 26'h3FFFFFF, 0, 0);
    #1;
    total++; if (cmp_stall !== 1'b1) begin bad++; $display("FAIL prio stall got %b exp 1", cmp_stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    tick();
    total++; if (rd_data !== 26'd0) begin bad++; $display("FAIL prio read got %0h exp 0", rd_data); end
    drive(0, 0, 0, 1, 5, 26'h3FFFFFF, 0, 0);
    #1;
    total++; if (cmp_stall !== 1'b0) begin bad++; $display("FAIL prio lone stall got %b exp 0", cmp_stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    tick();
    total++; if (rd_data !== 26'h3FFFFFF) begin bad++; $display("FAIL prio readback got %0h exp 3ffffff", rd_data); end
  endtask

  task automatic test_oob();
    drive(0, 0, 0, 1, 761, 26'h155, 0, 0);
    tick();
    total++; if (oob_err !== 1'b1) begin bad++; $display("FAIL oob pulse got %b exp 1", oob_err); end
    drive(0, 0, 0, 1, 1029, 26'h2AA, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    tick();
    total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL oob clear got %b exp 0", oob_err); end
    total++; if (rd_data !== 26'h3FFFFFF) begin bad++; $display("FAIL oob ram changed got %0h exp 3ffffff", rd_data); end
    do_reset();
    drive(1, 2000, 0, 0, 0, 0, 0, 0);
    tick();
    total++; if (oob_err !== 1'b1 || clr_busy !== 1'b0) begin bad++; $display("FAIL oob clr got oob=%b busy=%b exp 1/0", oob_err, clr_busy); end
    for (int a = 0; a < P; a++) begin
      drive(1, a, 0, 0, 0, 0, 0, 0);
      tick();
    end
    total++; if (clr_done !== 1'b1) begin bad++; $display("FAIL oob count done got %b exp 1", clr_done); end
    foreach (mem[i]) mem[i] = 26'd0;
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 0; a < 300; a++) begin
      drive(1, a, 0, 0, 0, 0, 0, 0);
      tick();
    end
    do_reset();
    total++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin bad++; $display("FAIL midrst got busy=%b done=%b exp 0/0", clr_busy, clr_done); end
    for (int a = 0; a < P; a++) begin
      drive(1, a, 0, 0, 0, 0, 0, 0);
      tick();
      total++; if (clr_done !== (a == P - 1)) begin bad++; $display("FAIL midrst done a=%0d got %b exp %b", a, clr_done, a == P - 1); end
    end
  endtask

  task automatic test_collision();
    logic [25:0] want;
`ifdef READ_BYPASS_EN
    want = 26'd9;
`else
    want = 26'd7;
`endif
    drive(0, 0, 0, 1, 10, 7, 0, 0);
    tick();
    drive(0, 0, 0, 1, 10, 9, 1, 10);
    tick();
    total++; if (rd_data !== want) begin bad++; $display("FAIL collide got %0d exp %0d", rd_data, want); end
    drive(0, 0, 0, 0, 0, 0, 1, 10);
    tick();
    total++; if (rd_data !== 26'd9) begin bad++; $display("FAIL collide next got %0d exp 9", rd_data); end
  endtask

  task automatic test_reclear();
    for (int a = 0; a < P; a++) begin
      drive(1, a, 26'($urandom), 0, 0, 0, 0, 0);
      tick();
      if (a == 0) begin
        total++; if (clr_done !== 1'b0 || clr_busy !== 1'b1) begin bad++; $display("FAIL reclear start got done=%b busy=%b exp 0/1", clr_done, clr_busy); end
      end
    end
    total++; if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin bad++; $display("FAIL reclear end got done=%b busy=%b exp 1/0", clr_done, clr_busy); end
    drive(0, 0, 0, 0, 0, 0, 1, 123);
    tick();
    total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL reclear read got %0h exp %0h", rd_data, exp_rd); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 799), 26'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 799), 26'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 799));
      #1;
      total++; if (cmp_stall !== (clr_we & cmp_we)) begin bad++; $display("FAIL rnd stall i=%0d got %b", i, cmp_stall); end
      tick();
      total++; if (rd_valid !== exp_valid || rd_data !== exp_rd) begin bad++; $display("FAIL rnd read i=%0d got %0h/%b exp %0h/%b", i, rd_data, rd_valid, exp_rd, exp_valid); end
      total++; if (oob_err !== exp_oob) begin bad++; $display("FAIL rnd oob i=%0d got %b exp %b", i, oob_err, exp_oob); end
      total++; if (clr_busy !== (phase == 1) || clr_done !== (phase == 2)) begin bad++; $display("FAIL rnd fsm i=%0d got busy=%b done=%b phase=%0d", i, clr_busy, clr_done, phase); end
    end
  endtask

  initial begin
    test_reset();
    test_full_clear();
    test_priority();
    test_oob();
    test_reset_mid_clear();
    test_collision();
    test_reclear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
